// File: rtl/avalon_mem_master.sv
// avalon_mem_master: Avalon-MM initiator turning single core load/store requests into
// bus transfers toward byte-addressed 32-bit memory slaves. One request in flight at a time.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready             core request handshake (ready only while idle)
//   req_write/req_size/req_signed   access kind, size (00 byte, 01 half, 10 word), load extension
//   req_addr/req_wdata              byte address, right-justified store data
//   resp_valid/resp_err/resp_rdata  one-cycle completion pulse, error flag, extended load data
//   address/read/write/writedata/byteenable/waitrequest/readdata   Avalon-MM master side
//
// Parameter MAX_WAIT bounds consecutive stalled cycles before abort (0 disables the timeout).
module avalon_mem_master #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdata, StErr} state_t;

    state_t      r_state;
    logic        r_is_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_address;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_writedata;
    logic [3:0]  r_byteenable;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_ext;
    logic [31:0] w_stall_next;
    logic        w_timeout;

    // Request decode: alignment check, lane enables and lane-shifted store data.
    // Lanes outside the access are forced to zero so writedata is deterministic.
    always_comb begin
        w_err   = 1'b0;
        w_be    = 4'b0000;
        w_wdata = '0;
        unique case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            2'b01: begin
                w_err   = req_addr[0];
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {16'b0, req_wdata[15:0]} << {req_addr[1:0], 3'b000};
            end
            2'b10: begin
                w_err   = (req_addr[1:0] != 2'b00);
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
            default: w_err = 1'b1;
        endcase
    end

    // Load extraction from the latched lane/size/sign of the request in flight.
    always_comb begin
        w_lane = readdata >> {r_lane, 3'b000};
        unique case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    assign w_stall_next = r_stall_cnt + 32'd1;
    assign w_timeout    = (MAX_WAIT != 0) && (w_stall_next == MAX_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_is_write   <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_lane       <= 2'b00;
            r_stall_cnt  <= '0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_stall_cnt <= '0;
                        if (w_err) begin
                            // Response is raised on entry so it is visible while in StErr,
                            // one cycle after the accept.
                            r_state      <= StErr;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state      <= StIssue;
                            r_is_write   <= req_write;
                            r_size       <= req_size;
                            r_signed     <= req_signed;
                            r_lane       <= req_addr[1:0];
                            r_address    <= {req_addr[31:2], 2'b00};
                            r_byteenable <= w_be;
                            r_writedata  <= req_write ? w_wdata : '0;
                            r_read       <= ~req_write;
                            r_write      <= req_write;
                        end
                    end
                end
                StIssue: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_is_write) begin
                            r_state      <= StIdle;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state <= StRdata;
                        end
                    end else begin
                        r_stall_cnt <= w_stall_next;
                        if (w_timeout) begin
                            r_read       <= 1'b0;
                            r_write      <= 1'b0;
                            r_state      <= StIdle;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end
                    end
                end
                StRdata: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_ext;
                end
                StErr: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;

endmodule

// File: tb/tb_avalon_mem_master.sv
// tb_avalon_mem_master: directed and randomized checks of avalon_mem_master against a
// byte-level reference memory. A second instance with MAX_WAIT=4 covers the stall timeout.
module tb_avalon_mem_master;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, address, writedata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;

    logic        req_valid_to, req_ready_to, resp_valid_to, resp_err_to;
    logic [31:0] resp_rdata_to, address_to, writedata_to;
    logic        read_to, write_to, wait_to;
    logic [3:0]  byteenable_to;

    avalon_mem_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    avalon_mem_master #(.MAX_WAIT(4)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_to), .req_ready(req_ready_to), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_to), .resp_err(resp_err_to),
        .resp_rdata(resp_rdata_to), .address(address_to), .read(read_to), .write(write_to),
        .waitrequest(wait_to), .writedata(writedata_to), .byteenable(byteenable_to),
        .readdata(readdata)
    );

    // Slave: registers readdata the cycle after an accepted read, byte-masked writes.
    logic [31:0] slave_mem [0:255] = '{default: '0};
    always @(posedge clk) begin
        if (read && !waitrequest) readdata <= slave_mem[address[9:2]];
        if (write && !waitrequest)
            for (int i = 0; i < 4; i++)
                if (byteenable[i]) slave_mem[address[9:2]][8*i +: 8] <= writedata[8*i +: 8];
    end

    // Reference memory, byte granular.
    logic [7:0] ref_mem [0:1023] = '{default: '0};

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] ad);
        return (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
    endfunction

    task automatic txn(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] ad,
                       input logic [31:0] wd, input int stalls, input string nm,
                       output logic [31:0] rd_o);
        bit          e, unstable, both;
        int          n, exp_lat, lat, strobes, stalled;
        longint      v;
        logic [9:0]  idx;
        logic [31:0] exp_rd, exp_wd, a0, wd0;
        logic [3:0]  exp_be, be0;
        logic [1:0]  dir0;
        logic        got_err;
        logic [31:0] got_rd;
        e = exp_err(sz, ad);
        n = 1 << sz;
        exp_rd = '0; exp_wd = '0; exp_be = '0;
        if (!e) begin
            exp_be = 4'(((1 << n) - 1) << ad[1:0]);
            v = (longint'(wd) & ((longint'(1) << (8 * n)) - 1)) << (8 * ad[1:0]);
            exp_wd = v[31:0];
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    idx = ad[9:0] + 10'(i);
                    ref_mem[idx] = 8'(wd >> (8 * i));
                end
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) begin
                    idx = ad[9:0] + 10'(i);
                    v = v + (longint'(ref_mem[idx]) << (8 * i));
                end
                if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                    v = v - (longint'(1) << (8 * n));
                exp_rd = v[31:0];
            end
        end
        exp_lat = e ? 1 : ((w ? 2 : 3) + stalls);

        req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1; waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; strobes = 0; stalled = 0; unstable = 0; both = 0;
        got_err = 1'b0; got_rd = '0; a0 = '0; wd0 = '0; be0 = '0; dir0 = '0;
        for (int c = 1; c <= 64; c++) begin
            if (resp_valid) begin
                lat = c; got_err = resp_err; got_rd = resp_rdata;
                break;
            end
            if (read && write) both = 1;
            if (read || write) begin
                if (strobes == 0) begin
                    a0 = address; be0 = byteenable; wd0 = writedata; dir0 = {read, write};
                end else if (address !== a0 || byteenable !== be0 || writedata !== wd0 ||
                             {read, write} !== dir0) begin
                    unstable = 1;
                end
                strobes++;
                waitrequest = (stalled < stalls);
                if (waitrequest) stalled++;
            end else begin
                waitrequest = 1'b0;
            end
            @(negedge clk);
        end
        waitrequest = 1'b0;

        chk({nm, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".err"}, {31'b0, got_err}, {31'b0, e});
        chk({nm, ".rdata"}, got_rd, exp_rd);
        chk({nm, ".strobes"}, 32'(strobes), e ? 32'd0 : 32'(stalls + 1));
        chk({nm, ".both"}, {31'b0, both}, 32'd0);
        if (!e) begin
            chk({nm, ".addr"}, a0, {ad[31:2], 2'b00});
            chk({nm, ".be"}, {28'b0, be0}, {28'b0, exp_be});
            chk({nm, ".dir"}, {30'b0, dir0}, w ? 32'd1 : 32'd2);
            chk({nm, ".stable"}, {31'b0, unstable}, 32'd0);
            if (w) chk({nm, ".wdata"}, wd0, exp_wd);
        end
        @(negedge clk);
        chk({nm, ".pulse"}, {31'b0, resp_valid}, 32'd0);
        chk({nm, ".ready"}, {31'b0, req_ready}, 32'd1);
        rd_o = got_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int          lat, strobes;
        logic [31:0] a_to;
        logic [3:0]  be_to;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; waitrequest = 1'b0;
        req_valid_to = 1'b0; wait_to = 1'b0;

        // Reset values.
        #1 reset = 1'b1;
        #1;
        chk("rst.read", {31'b0, read}, 32'd0);
        chk("rst.write", {31'b0, write}, 32'd0);
        chk("rst.be", {28'b0, byteenable}, 32'd0);
        chk("rst.addr", address, 32'd0);
        chk("rst.wdata", writedata, 32'd0);
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.to_wdata", writedata_to, 32'd0);
        chk("rst.to_rdata", resp_rdata_to, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready", {31'b0, req_ready}, 32'd1);

        // Word write then read back.
        txn(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, "wr_word", r);
        txn(0, 2'b10, 0, 32'h100, 32'h0, 0, "rd_word", r);
        chk("rd_word.value", r, 32'hDEADBEEF);

        // Byte lanes.
        txn(1, 2'b00, 0, 32'h200, 32'h11, 0, "wr_b0", r);
        txn(1, 2'b00, 0, 32'h201, 32'h22, 0, "wr_b1", r);
        txn(1, 2'b00, 0, 32'h202, 32'h33, 0, "wr_b2", r);
        txn(1, 2'b00, 0, 32'h203, 32'h44, 0, "wr_b3", r);
        txn(0, 2'b10, 0, 32'h200, 32'h0, 0, "rd_bytes", r);
        chk("rd_bytes.value", r, 32'h44332211);
        txn(0, 2'b00, 1, 32'h203, 32'h0, 0, "rd_sb3", r);
        chk("rd_sb3.value", r, 32'h00000044);
        txn(1, 2'b00, 0, 32'h201, 32'h80, 0, "wr_b80", r);
        txn(0, 2'b00, 1, 32'h201, 32'h0, 0, "rd_sb80", r);
        chk("rd_sb80.value", r, 32'hFFFFFF80);
        txn(0, 2'b00, 0, 32'h201, 32'h0, 0, "rd_ub80", r);
        chk("rd_ub80.value", r, 32'h00000080);

        // Halfword at upper lanes.
        txn(1, 2'b01, 0, 32'h302, 32'h8001, 0, "wr_half", r);
        txn(0, 2'b01, 1, 32'h302, 32'h0, 0, "rd_sh", r);
        chk("rd_sh.value", r, 32'hFFFF8001);

        // Misaligned and illegal requests.
        txn(0, 2'b10, 0, 32'h101, 32'h0, 0, "err_word", r);
        txn(1, 2'b01, 0, 32'h103, 32'h5555, 0, "err_half", r);
        txn(0, 2'b11, 0, 32'h100, 32'h0, 0, "err_size", r);

        // Five stalled cycles on a read.
        txn(0, 2'b10, 0, 32'h100, 32'h0, 5, "stall", r);
        chk("stall.value", r, 32'hDEADBEEF);

        // Timeout on the MAX_WAIT=4 instance with waitrequest stuck high.
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100;
        req_valid_to = 1'b1; wait_to = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_to = 1'b0;
        lat = -1; strobes = 0; a_to = '0; be_to = '0;
        for (int c = 1; c <= 20; c++) begin
            if (resp_valid_to) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                a_to = address_to; be_to = byteenable_to;
            end
            if (read_to) strobes++;
            @(negedge clk);
        end
        chk("to.lat", 32'(lat), 32'd5);
        chk("to.strobes", 32'(strobes), 32'd4);
        chk("to.addr", a_to, 32'h100);
        chk("to.be", {28'b0, be_to}, 32'hF);
        chk("to.err", {31'b0, resp_err_to}, 32'd1);
        chk("to.rdata", resp_rdata_to, 32'd0);
        chk("to.read", {31'b0, read_to}, 32'd0);
        chk("to.write", {31'b0, write_to}, 32'd0);
        chk("to.ready", {31'b0, req_ready_to}, 32'd1);
        @(negedge clk);
        chk("to.pulse", {31'b0, resp_valid_to}, 32'd0);
        wait_to = 1'b0;

        // Reset during a stalled write: strobe drops without a clock edge, no response.
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h104; req_wdata = 32'h12345678;
        req_valid = 1'b1; waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmid.write_on", {31'b0, write}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rmid.write_off", {31'b0, write}, 32'd0);
        chk("rmid.resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rmid.noresp", {31'b0, resp_valid}, 32'd0);
            chk("rmid.ready", {31'b0, req_ready}, 32'd1);
        end
        txn(0, 2'b10, 0, 32'h100, 32'h0, 0, "rmid.read", r);
        chk("rmid.value", r, 32'hDEADBEEF);

        // Randomized traffic in the low 256 bytes.
        for (int k = 0; k < 40; k++) begin
            bit          w, sg;
            logic [1:0]  sz;
            logic [31:0] ad, wd;
            int          st;
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0 && sz != 2'b11)
                ad = ad & ~32'((1 << sz) - 1);
            wd = $urandom;
            st = $urandom_range(0, 3);
            txn(w, sz, sg, ad, wd, st, "rand", r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
